// File: rtl/mips_fetch_if.sv
// Fetch-stage bundle: decode-side control, program-load port and IF/ID outputs.
// master drives stall/branch/load and observes the stage; slave is the stage itself.
interface mips_fetch_if #(
    parameter int unsigned NUM_INSTRUCTIONS = 32
);
    localparam int unsigned AW = $clog2(NUM_INSTRUCTIONS);

    logic          STALL_pi;
    logic          BRANCH_TAKEN_pi;
    logic [31:0]   BRANCH_TARGET_pi;
    logic          IMEM_WE_pi;
    logic [AW-1:0] IMEM_WADDR_pi;
    logic [31:0]   IMEM_WDATA_pi;
    logic [31:0]   PC_po;
    logic [31:0]   IFID_INSTR_po;
    logic [31:0]   IFID_PC4_po;
    logic          IFID_VALID_po;
    logic          HALT_po;

    modport master (
        output STALL_pi, BRANCH_TAKEN_pi, BRANCH_TARGET_pi,
        output IMEM_WE_pi, IMEM_WADDR_pi, IMEM_WDATA_pi,
        input  PC_po, IFID_INSTR_po, IFID_PC4_po, IFID_VALID_po, HALT_po
    );

    modport slave (
        input  STALL_pi, BRANCH_TAKEN_pi, BRANCH_TARGET_pi,
        input  IMEM_WE_pi, IMEM_WADDR_pi, IMEM_WDATA_pi,
        output PC_po, IFID_INSTR_po, IFID_PC4_po, IFID_VALID_po, HALT_po
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch: PC, instruction memory and the IF/ID register.
// Sticky halt once the PC walks past the loaded program.
module mips_fetch_stage #(
    parameter int unsigned NUM_INSTRUCTIONS = 32,
    parameter logic [31:0] RESET_PC         = 32'h0000_0000
) (
    input logic        CLK_pi,
    input logic        CPU_RESET_pi,
    mips_fetch_if.slave fetch
);
    localparam int unsigned AW = $clog2(NUM_INSTRUCTIONS);

    logic [31:0] mem [NUM_INSTRUCTIONS];

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;

    logic        in_range;
    logic [31:0] fetch_word;

    assign in_range   = {2'b00, pc_q[31:2]} < 32'(NUM_INSTRUCTIONS);
    assign fetch_word = in_range ? mem[pc_q[AW+1:2]] : 32'h0;

    // Program load is independent of reset/halt; the read above sees the pre-edge word.
    always_ff @(posedge CLK_pi) begin
        if (fetch.IMEM_WE_pi && (32'(fetch.IMEM_WADDR_pi) < NUM_INSTRUCTIONS)) begin
            mem[fetch.IMEM_WADDR_pi] <= fetch.IMEM_WDATA_pi;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        if (!halt_q) begin
            if (fetch.BRANCH_TAKEN_pi) begin
                pc_d    = {fetch.BRANCH_TARGET_pi[31:2], 2'b00};
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
            end else if (!fetch.STALL_pi) begin
                if (in_range) begin
                    instr_d = fetch_word;
                    pc4_d   = pc_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end else begin
                    instr_d = 32'h0;
                    pc4_d   = 32'h0;
                    valid_d = 1'b0;
                    halt_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK_pi) begin
        if (CPU_RESET_pi) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

    assign fetch.PC_po         = pc_q;
    assign fetch.IFID_INSTR_po = instr_q;
    assign fetch.IFID_PC4_po   = pc4_q;
    assign fetch.IFID_VALID_po = valid_q;
    assign fetch.HALT_po       = halt_q;
endmodule

// File: tb/tb_mips_fetch_stage.sv
// Randomized bench for mips_fetch_stage against a cycle-level reference model.
module tb_mips_fetch_stage;
    localparam int unsigned N  = 12;
    localparam int unsigned AW = $clog2(N);
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_fetch_if #(.NUM_INSTRUCTIONS(N)) bus ();

    mips_fetch_stage #(.NUM_INSTRUCTIONS(N), .RESET_PC(RPC)) dut (
        .CLK_pi       (clk),
        .CPU_RESET_pi (rst),
        .fetch        (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference state
    logic [31:0] m_mem [N];
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    // One clock edge of the behavioural model, using the inputs currently applied.
    task automatic model_edge();
        int unsigned idx;
        logic [31:0] old_word;
        idx      = m_pc / 4;
        old_word = (idx < N) ? m_mem[idx] : 32'h0;
        if (bus.IMEM_WE_pi && int'(bus.IMEM_WADDR_pi) < int'(N))
            m_mem[bus.IMEM_WADDR_pi] = bus.IMEM_WDATA_pi;
        if (rst) begin
            m_pc = RPC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0;
        end else if (m_halt) begin
            // frozen until reset
        end else if (bus.BRANCH_TAKEN_pi) begin
            m_pc = bus.BRANCH_TARGET_pi & ~32'd3;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (bus.STALL_pi) begin
            // hold
        end else if (idx < N) begin
            m_instr = old_word; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
        end else begin
            m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 1;
        end
    endtask

    task automatic step_and_check();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("pc",    bus.PC_po,         m_pc);
        check("instr", bus.IFID_INSTR_po, m_instr);
        check("pc4",   bus.IFID_PC4_po,   m_pc4);
        check("valid", 32'(bus.IFID_VALID_po), 32'(m_valid));
        check("halt",  32'(bus.HALT_po),       32'(m_halt));
    endtask

    initial begin
        bus.STALL_pi         = 1'b0;
        bus.BRANCH_TAKEN_pi  = 1'b0;
        bus.BRANCH_TARGET_pi = 32'h0;
        bus.IMEM_WE_pi       = 1'b0;
        bus.IMEM_WADDR_pi    = '0;
        bus.IMEM_WDATA_pi    = 32'h0;
        m_pc = 32'hx; m_instr = 32'hx; m_pc4 = 32'hx; m_valid = 1'bx; m_halt = 1'bx;

        // Load every index, including those past the program, while reset is held.
        for (int i = 0; i < (1 << AW); i++) begin
            bus.IMEM_WE_pi    = 1'b1;
            bus.IMEM_WADDR_pi = AW'(i);
            bus.IMEM_WDATA_pi = $urandom;
            step_and_check();
        end
        bus.IMEM_WE_pi = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            rst                  = ($urandom_range(0, 99) < 3);
            bus.STALL_pi         = ($urandom_range(0, 99) < 20);
            bus.BRANCH_TAKEN_pi  = ($urandom_range(0, 99) < 8);
            bus.BRANCH_TARGET_pi = 32'($urandom_range(0, (N + 3) * 4));
            bus.IMEM_WE_pi       = ($urandom_range(0, 99) < 30);
            bus.IMEM_WDATA_pi    = $urandom;
            if ($urandom_range(0, 1) == 1) bus.IMEM_WADDR_pi = m_pc[AW+1:2];
            else bus.IMEM_WADDR_pi = AW'($urandom);
            step_and_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
